// File: rtl/uart_cmd_controller_if.sv
// UART-side bundle: receive strobe/byte in, transmit request/byte out, transmitter busy back.
// master = command controller, slave = UART receiver/transmitter pair.
interface uart_cmd_controller_if;
  logic [7:0] RData;
  logic       DVPulse;
  logic       TxBusy;
  logic [7:0] TxData;
  logic       TxStart;

  modport master (input RData, DVPulse, TxBusy, output TxData, TxStart);
  modport slave  (output RData, DVPulse, TxBusy, input TxData, TxStart);
endinterface

// File: rtl/uart_cmd_controller.sv
// Line command controller: buffers RX bytes, decodes on CR, replies 'A'/'E' then CR via the UART TX.
// Latency: CR-to-TxStart is 3 cycles; CmdDone 1 cycle after the final TX byte completes.
// Backpressure: TX is paced by TxBusy; RX bytes arriving while busy are dropped and counted.
module uart_cmd_controller #(
  parameter int MAXLEN = 8
) (
  input  logic                  i_Clk50M,
  input  logic                  i_Rst,
  uart_cmd_controller_if.master bus,
  output logic                  o_LedOn,
  output logic                  o_OkTog,
  output logic                  o_CmdDone,
  output logic                  o_Busy,
  output logic [7:0]            o_DropCnt
);

  localparam int LW   = $clog2(MAXLEN + 1);
  // at least three entries so "off" can always be compared at fixed indices
  localparam int BUFD = (MAXLEN < 3) ? 3 : MAXLEN;

  typedef enum logic [2:0] {
    S_COLLECT, S_DECODE, S_SEND0, S_SEND1, S_WAITHI, S_WAITLO, S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_buf [BUFD];
  logic [LW-1:0] r_len;
  logic        r_ovf;
  logic        r_ack;
  logic        r_idx;
  logic [2:0]  r_tmo;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_led;
  logic        r_tog;
  logic        r_cmd_done;
  logic        r_busy;
  logic [7:0]  r_drop_cnt;

  logic w_is_ok;
  logic w_is_on;
  logic w_is_off;
  logic w_accept;

  assign w_is_ok  = (r_len == LW'(2)) && (r_buf[0] == 8'd111) && (r_buf[1] == 8'd107);
  assign w_is_on  = (r_len == LW'(2)) && (r_buf[0] == 8'd111) && (r_buf[1] == 8'd110);
  assign w_is_off = (r_len == LW'(3)) && (r_buf[0] == 8'd111) && (r_buf[1] == 8'd102)
                    && (r_buf[2] == 8'd102);
  assign w_accept = !r_ovf && (w_is_ok || w_is_on || w_is_off);

  always_ff @(posedge i_Clk50M) begin
    if (i_Rst) begin
      r_state    <= S_COLLECT;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_ack      <= 1'b0;
      r_idx      <= 1'b0;
      r_tmo      <= 3'd0;
      r_tx_data  <= 8'd0;
      r_tx_start <= 1'b0;
      r_led      <= 1'b0;
      r_tog      <= 1'b0;
      r_cmd_done <= 1'b0;
      r_busy     <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_tx_start <= 1'b0;
      r_cmd_done <= 1'b0;
      if (bus.DVPulse && (r_state != S_COLLECT) && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        S_COLLECT: begin
          if (bus.DVPulse) begin
            if (bus.RData == 8'd13) begin
              r_state <= S_DECODE;
              r_busy  <= 1'b1;
            end else if (bus.RData != 8'd10) begin
              if (r_len < LW'(MAXLEN)) begin
                for (int i = 0; i < BUFD; i++)
                  if (r_len == LW'(i)) r_buf[i] <= bus.RData;
                r_len <= r_len + LW'(1);
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end
        end
        S_DECODE: begin
          if (!r_ovf && w_is_ok)  r_tog <= ~r_tog;
          if (!r_ovf && w_is_on)  r_led <= 1'b1;
          if (!r_ovf && w_is_off) r_led <= 1'b0;
          r_ack   <= w_accept;
          r_len   <= '0;
          r_ovf   <= 1'b0;
          r_state <= S_SEND0;
        end
        S_SEND0, S_SEND1: begin
          if (!bus.TxBusy) begin
            r_tx_data  <= (r_state == S_SEND1) ? 8'd13 : (r_ack ? 8'd65 : 8'd69);
            r_tx_start <= 1'b1;
            r_idx      <= (r_state == S_SEND1);
            r_tmo      <= 3'd0;
            r_state    <= S_WAITHI;
          end
        end
        S_WAITHI: begin
          if (bus.TxBusy) begin
            r_state <= S_WAITLO;
          end else if (r_tmo == 3'd3) begin
            // transmitter never acknowledged: treat the byte as sent
            if (r_idx) begin
              r_state    <= S_DONE;
              r_cmd_done <= 1'b1;
            end else begin
              r_state <= S_SEND1;
            end
          end else begin
            r_tmo <= r_tmo + 3'd1;
          end
        end
        S_WAITLO: begin
          if (!bus.TxBusy) begin
            if (r_idx) begin
              r_state    <= S_DONE;
              r_cmd_done <= 1'b1;
            end else begin
              r_state <= S_SEND1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_COLLECT;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_COLLECT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TxData  = r_tx_data;
  assign bus.TxStart = r_tx_start;
  assign o_LedOn     = r_led;
  assign o_OkTog     = r_tog;
  assign o_CmdDone   = r_cmd_done;
  assign o_Busy      = r_busy;
  assign o_DropCnt   = r_drop_cnt;

endmodule

// File: doc/uart_cmd_controller.md
# uart_cmd_controller

Line-oriented command controller on the UART receive path. It collects received bytes into a line buffer. On carriage return it decodes the line against a fixed command set and applies the command's effect. It then sequences a two-byte acknowledge or error reply through the UART transmitter handshake. It sits between the UART receiver (RData/DVPulse) and the UART transmitter (TxData/TxStart/TxBusy), and it owns the transmitter while it is replying.

## Interface
- MAXLEN, 8: line buffer depth in bytes; legal range 2..16.
- Clk50M  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- RData  in  8  received byte; valid only while DVPulse=1.
- DVPulse  in  1  one-cycle strobe marking a new RData byte.
- TxBusy  in  1  transmitter busy flag; rises no later than 2 cycles after TxStart and falls when the byte has been sent.
- TxData  out  8  byte to transmit; held stable from TxStart until TxBusy falls.
- TxStart  out  1  one-cycle transmit request.
- LedOn  out  1  level set by the "on" command and cleared by the "off" command.
- OkTog  out  1  toggles once per accepted "ok" command.
- CmdDone  out  1  one-cycle pulse when a reply has fully completed.
- Busy  out  1  high whenever the state is not COLLECT.
- DropCnt  out  8  saturating count of bytes dropped while Busy=1.

## Operation
- Reset: state COLLECT, line length 0, overflow flag 0. All outputs are 0: TxData=0, TxStart=0, LedOn=0, OkTog=0, CmdDone=0, Busy=0, DropCnt=0. Reset takes effect mid-reply as well: TxStart is forced low immediately, and the transmitter is left to finish the byte it already has.
- COLLECT, handling of a byte on DVPulse:
  - 13 (CR): go to DECODE.
  - 10 (LF): ignored.
  - Any other byte with length<MAXLEN: stored at index length, then length+1.
  - Any other byte with length==MAXLEN: discarded and overflow flag set; stays in COLLECT until CR arrives.
- DECODE lasts one cycle and matches the exact line, case-sensitive:
  - "ok" (111,107): OkTog inverts.
  - "on" (111,110): LedOn<=1.
  - "off" (111,102,102): LedOn<=1'b0.
  - Accepted command: reply is 'A'(65) then CR(13).
  - Empty line, unknown line, or overflow flag set: no effect; reply is 'E'(69) then CR(13).
  - At exit, length and overflow flag are cleared and the state goes to SEND0.
- SEND0/SEND1:
  - When TxBusy=0: drive TxData with the reply byte, pulse TxStart, go to WAITHI.
  - WAITHI: wait for TxBusy=1, then go to WAITLO.
  - WAITLO: wait for TxBusy=0, then advance to the next byte. After byte 1, go to DONE.
  - If TxBusy does not rise within 4 cycles of TxStart in WAITHI, the byte counts as sent and the sequence advances.
- DONE lasts one cycle: CmdDone=1, then return to COLLECT.
- DVPulse while Busy=1 (DECODE through DONE): the byte is dropped and DropCnt+1, saturating at 255. Dropped bytes, including a CR, are never buffered.
- Arithmetic:
  - Length counter is $clog2(MAXLEN+1) bits wide and never wraps.
  - Timeout counter is 3 bits.

## Timing
- Cycle N is the cycle in which DVPulse=1 with RData=13 is sampled.
  - N+1: state DECODE, Busy=1.
  - N+2: LedOn/OkTog hold their new values; state SEND0.
  - N+3: TxStart=1 and TxData valid, when TxBusy=0 during N+2.
- TxStart is always exactly one cycle wide. TxData changes only in the cycle TxStart is asserted.
- Second TxStart comes no earlier than 2 cycles after TxBusy falls.
- CmdDone is asserted 1 cycle after the final WAITLO exit. Busy=0 from the following cycle.
- A DVPulse in the same cycle that the state returns to COLLECT is accepted normally.

## Test plan
- Reset, then bytes "ok",13 with a transmitter model (TxBusy high 10 cycles) -> OkTog 0->1 at N+2; TxStart at N+3 with TxData=65; second TxStart with TxData=13; one CmdDone pulse; Busy=0.
- "on",13, then "off",10,13 -> LedOn=1 after the first line and 0 after the second; both replies 65,13; LF has no effect.
- "xy",13 and an empty 13 -> LedOn and OkTog unchanged; each reply is 69,13.
- Ten 'o' bytes then 13 with MAXLEN=8 -> reply 69,13; the next line "ok",13 is accepted (length and overflow were cleared).
- Send "ok",13 and inject 3 DVPulse bytes during the reply -> DropCnt=3; OkTog toggles once. Inject 300 drops -> DropCnt=255.
- TxBusy tied low -> each byte advances after the 4-cycle timeout; CmdDone still pulses. Assert Rst during WAITLO -> all outputs 0 in the next cycle and state is COLLECT.
